// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the UART receive path.
//   UART_DATA_W     - bits per character
//   DEFAULT_*       - default parameter values for the controller and FIFO
//   LINE_IDLE       - level of the idle serial line (start bit is the opposite)
//   rx_state_t      - frame-receiver states
package uart_pkg;

   localparam int UART_DATA_W     = 8;
   localparam int DEFAULT_DIV_W   = 16;
   localparam int DEFAULT_DIV     = 1;
   localparam int DEFAULT_DEPTH   = 4;
   localparam int DEFAULT_TIMEOUT = 1024;

   localparam logic LINE_IDLE = 1'b0;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: circular-buffer FIFO with wrap-bit pointers.
//   clk, rst_n  clock, asynchronous active-low reset (clears contents too)
//   push, wdata write request; accepted when not full, or full with a pop
//   pop         read request; ignored when empty
//   rdata       head entry (combinational)
//   full, empty, level  occupancy status
module byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int W     = UART_DATA_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [W-1:0] mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign do_pop  = pop & ~empty;
   // When full, a simultaneous pop frees the slot being written.
   assign do_push = push & (~full | do_pop);
   assign level   = wr_ptr - rd_ptr;
   assign rdata   = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: frame receiver. One bit is sampled per rising edge of samp_clk,
// detected synchronously in the ref_clk domain.
//   ref_clk  in   system clock
//   samp_clk in   sample clock (one bit period per samp_clk period)
//   reset    in   asynchronous, active-high reset
//   in       in   serial line (idle LINE_IDLE, start bit ~LINE_IDLE, LSB first)
//   out      out  last received byte, held while ready=1
//   ready    out  high from a good stop bit until the next start bit
module uart_rx
   import uart_pkg::*;
(
   input  logic                   ref_clk,
   input  logic                   samp_clk,
   input  logic                   reset,
   input  logic                   in,
   output logic [UART_DATA_W-1:0] out,
   output logic                   ready
);

   rx_state_t              state;
   logic                   samp_q;
   logic [2:0]             bit_idx;
   logic [UART_DATA_W-1:0] shift;
   logic                   tick;

   assign tick = samp_clk & ~samp_q;

   always_ff @(posedge ref_clk or posedge reset) begin
      if (reset) begin
         state   <= RX_IDLE;
         samp_q  <= 1'b0;
         bit_idx <= '0;
         shift   <= '0;
         out     <= '0;
         ready   <= 1'b0;
      end else begin
         samp_q <= samp_clk;
         if (tick) begin
            case (state)
               RX_IDLE: begin
                  if (in != LINE_IDLE) begin
                     state   <= RX_DATA;
                     bit_idx <= '0;
                     ready   <= 1'b0;
                  end
               end
               RX_DATA: begin
                  shift   <= {in, shift[UART_DATA_W-1:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) state <= RX_STOP;
               end
               RX_STOP: begin
                  // A bad stop bit silently discards the frame.
                  if (in == LINE_IDLE) begin
                     out   <= shift;
                     ready <= 1'b1;
                  end
                  state <= RX_IDLE;
               end
               default: state <= RX_IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller around one uart_rx.
//   ref_clk      in   system clock
//   reset        in   asynchronous, active-low reset
//   rx_enable    in   1 = receiver runs, 0 = uart_rx held in reset
//   div          in   samp_clk half-period in ref_clk cycles (0 acts as 1)
//   in           in   serial line
//   out_data     out  FIFO head byte
//   out_valid    out  FIFO not empty
//   out_ack      in   pop head (ignored when out_valid=0)
//   overrun      out  sticky byte-dropped flag
//   overrun_clr  in   clears overrun (a same-cycle new overrun wins)
//   idle_timeout out  one-cycle pulse after TIMEOUT idle cycles following a byte
//   fifo_level   out  stored byte count
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int DIV_W   = DEFAULT_DIV_W,
   parameter int DEPTH   = DEFAULT_DEPTH,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic                   ref_clk,
   input  logic                   reset,
   input  logic                   rx_enable,
   input  logic [DIV_W-1:0]       div,
   input  logic                   in,
   output logic [UART_DATA_W-1:0] out_data,
   output logic                   out_valid,
   input  logic                   out_ack,
   output logic                   overrun,
   input  logic                   overrun_clr,
   output logic                   idle_timeout,
   output logic [$clog2(DEPTH):0] fifo_level
);

   localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   logic [DIV_W-1:0]       div_cnt;
   logic [DIV_W-1:0]       div_lat;
   logic [DIV_W-1:0]       div_top;
   logic                   samp_clk;
   logic                   rx_rst;
   logic [UART_DATA_W-1:0] rx_data;
   logic                   rx_ready;
   logic                   ready_r;
   logic                   ready_q;
   logic                   push;
   logic                   full;
   logic                   empty;
   logic [TO_W-1:0]        to_cnt;
   logic                   armed;

   // Divisor is latched at each wrap so a change never shortens a half-period in flight.
   assign div_top = (div_lat == '0) ? '0 : div_lat - DIV_W'(1);

   always_ff @(posedge ref_clk or negedge reset) begin
      if (!reset) begin
         div_cnt  <= '0;
         div_lat  <= '0;
         samp_clk <= 1'b0;
      end else if (div_cnt == div_top) begin
         div_cnt  <= '0;
         div_lat  <= div;
         samp_clk <= ~samp_clk;
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   assign rx_rst = ~reset | ~rx_enable;

   uart_rx u_rx (
      .ref_clk  (ref_clk),
      .samp_clk (samp_clk),
      .reset    (rx_rst),
      .in       (in),
      .out      (rx_data),
      .ready    (rx_ready)
   );

   always_ff @(posedge ref_clk or negedge reset) begin
      if (!reset) begin
         ready_r <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         ready_r <= rx_ready;
         ready_q <= ready_r;
      end
   end

   assign push = ready_r & ~ready_q;

   byte_fifo #(
      .DEPTH (DEPTH),
      .W     (UART_DATA_W)
   ) u_fifo (
      .clk   (ref_clk),
      .rst_n (reset),
      .push  (push),
      .wdata (rx_data),
      .pop   (out_ack),
      .rdata (out_data),
      .full  (full),
      .empty (empty),
      .level (fifo_level)
   );

   assign out_valid = ~empty;

   always_ff @(posedge ref_clk or negedge reset) begin
      if (!reset) begin
         overrun <= 1'b0;
      end else if (push && full && !out_ack) begin
         overrun <= 1'b1;
      end else if (overrun_clr) begin
         overrun <= 1'b0;
      end
   end

   // Pulse is registered on the edge where the count reaches TIMEOUT-1,
   // so it is visible TIMEOUT cycles after the push cycle.
   always_ff @(posedge ref_clk or negedge reset) begin
      if (!reset) begin
         to_cnt       <= '0;
         armed        <= 1'b0;
         idle_timeout <= 1'b0;
      end else begin
         idle_timeout <= 1'b0;
         if (push) begin
            to_cnt <= '0;
            armed  <= 1'b1;
         end else if (armed && rx_enable) begin
            if (in != LINE_IDLE) begin
               to_cnt <= '0;
            end else if (to_cnt == TO_W'(TIMEOUT - 2)) begin
               to_cnt       <= to_cnt + TO_W'(1);
               idle_timeout <= 1'b1;
               armed        <= 1'b0;
            end else begin
               to_cnt <= to_cnt + TO_W'(1);
            end
         end
      end
   end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side controller that wraps one uart_rx instance.
- Generates the uart_rx sample clock from a programmable divisor and gates the receiver on/off.
- Captures each completed byte into a small FIFO with a valid/ack handshake, flags overrun, and reports an inter-byte idle timeout.
- Sits between the serial pin and the consumer logic (command parser / host bus).

Parameters:
- DIV_W, 16, width of the baud divisor input.
- DEPTH, 4, FIFO depth in bytes; must be a power of two, minimum 2.
- TIMEOUT, 1024, ref_clk cycles of idle line after the last byte before idle_timeout pulses.

Ports:
- ref_clk  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_enable  in  1  1 = receiver runs; 0 = uart_rx held in reset, FIFO contents kept.
- div  in  DIV_W  samp_clk half-period in ref_clk cycles; 0 is treated as 1.
- in  in  1  serial line; idle low, start bit high, 8 data bits LSB first, stop low.
- out_data  out  8  byte at the FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ack  in  1  pops the head when out_valid=1; ignored when out_valid=0.
- overrun  out  1  sticky: a byte was dropped because the FIFO was full.
- overrun_clr  in  1  clears overrun.
- idle_timeout  out  1  one-cycle pulse.
- fifo_level  out  $clog2(DEPTH)+1  number of stored bytes.

Behaviour:
- Reset (reset=0): all outputs 0; FIFO empty; divider counter 0; samp_clk 0; timeout disarmed.
- Sample clock:
  - Register samp_clk toggles when div_cnt reaches max(div,1)-1; div_cnt then returns to 0.
  - A new div value takes effect at the next wrap.
  - samp_clk drives uart_rx.samp_clk. uart_rx.ref_clk = ref_clk.
  - uart_rx.reset = ~reset | ~rx_enable (active-high into the submodule).
- Byte capture:
  - ready is registered once; the push strobe is the rising edge of the registered ready (ready=1, ready_q=0).
  - Push writes uart_rx.out into the FIFO. out_valid rises 1 cycle after the push cycle, giving 2 ref_clk cycles from ready rising to out_valid.
- FIFO:
  - Circular buffer; read/write pointers with 1 extra wrap bit; full = same index, different wrap bit.
  - out_data is a combinational read of the head entry.
- Simultaneous events:
  - Push and pop in the same cycle: both occur; level unchanged. This holds when full (no overrun) and when empty (out_valid was 0, so no pop; push only).
  - Push when full with no pop: byte dropped, overrun=1 next cycle.
  - overrun_clr and a new overrun in the same cycle: set wins.
- Idle timeout:
  - Counter reset to 0 and armed on every push.
  - While armed, rx_enable=1 and in=0, it increments each cycle; in=1 resets it to 0 without disarming.
  - On reaching TIMEOUT-1: idle_timeout=1 for one cycle, then disarm. The timeout fires once per burst.
- rx_enable=0 mid-frame: uart_rx aborts with the partial byte discarded; timeout counter held; FIFO and overrun unchanged.
- reset mid-operation: immediate clear of everything, including FIFO contents.

Decomposition:
- Shared package uart_pkg: UART_DATA_W=8; default divisor/timeout constants; line idle level = 0.
- One natural sub-module: byte_fifo (DEPTH-parameterised, push/pop/full/empty/level), reusable by the TX path.
- Divider, edge detect and timeout stay in uart_rx_ctrl.

Test Plan:
- Reset/idle: reset=0 for 4 cycles, then 1, in=0, div=1 -> out_valid=0, overrun=0, fifo_level=0, idle_timeout never pulses.
- Single byte: send 8'hAC at div=1, out_ack=0 -> out_valid=1 exactly 2 cycles after ready rises; out_data=8'hAC, fifo_level=1; ack -> out_valid=0 next cycle.
- Burst plus overrun: DEPTH=4, send 8'h93, 8'h4D, 8'h01, 8'h02, 8'h03 with no ack -> fifo_level=4, overrun=1; pops yield 93,4D,01,02; overrun_clr -> overrun=0.
- Push and pop together when full: hold out_ack=1 as the 5th byte completes -> no overrun; level stays 4; order preserved.
- Timeout: TIMEOUT=16, one byte then in=0 -> single idle_timeout pulse 16 cycles after the push; no second pulse; a new byte re-arms.
- Enable/reset abort: drop rx_enable halfway through a frame -> no push, FIFO unchanged. Repeat with reset=0 -> all outputs 0 within the same cycle.
